rob_multi_dispatch: RTL



---
 rtl/rob_multi_dispatch.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rob_multi_dispatch.sv
// Reorder buffer: multi-lane in-order allocation, multi-port completion,
// single-entry in-order retire, and a full flush.
module rob_multi_dispatch #(
  parameter int unsigned ROB_ENTRIES = 16,
  parameter int unsigned DISP_WIDTH  = 2,
  parameter int unsigned WB_PORTS    = 2,
  localparam int unsigned IDX_W      = $clog2(ROB_ENTRIES),
  localparam int unsigned CNT_W      = IDX_W + 1
) (
  input  logic                        clk,
  input  logic                        n_rst,
  // dispatch / allocation
  input  logic [DISP_WIDTH-1:0]       disp_valid,
  input  logic [5*DISP_WIDTH-1:0]     disp_dest_reg,
  input  logic [DISP_WIDTH-1:0]       disp_wb_en,
  output logic [IDX_W*DISP_WIDTH-1:0] disp_rob_idx,
  output logic                        rob_full,
  output logic [CNT_W-1:0]            rob_free_cnt,
  // writeback / completion
  input  logic [WB_PORTS-1:0]         wb_valid,
  input  logic [IDX_W*WB_PORTS-1:0]   wb_rob_idx,
  // commit / retire
  output logic                        commit_valid,
  input  logic                        commit_ready,
  output logic [4:0]                  commit_dest_reg,
  output logic                        commit_wb_en,
  output logic [IDX_W-1:0]            commit_rob_idx,
  // flush
  input  logic                        flush
);

  localparam int unsigned DEST_W = 5;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [DEST_W-1:0] dest_reg;
    logic              wb_en;
  } rob_entry_t;

  rob_entry_t       entry_q [ROB_ENTRIES];
  rob_entry_t       entry_d [ROB_ENTRIES];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [IDX_W-1:0] lane_idx [DISP_WIDTH];
  logic [CNT_W-1:0] alloc_num;
  logic [IDX_W-1:0] wb_idx   [WB_PORTS];
  logic             alloc_fire;
  logic             commit_fire;

  // Free count and full flag come only from registered occupancy.
  assign rob_free_cnt = CNT_W'(ROB_ENTRIES) - count_q;
  assign rob_full     = (rob_free_cnt < CNT_W'(DISP_WIDTH));

  // Head entry drives the commit interface.
  assign commit_valid    = entry_q[head_q].valid & entry_q[head_q].done;
  assign commit_dest_reg = entry_q[head_q].dest_reg;
  assign commit_wb_en    = entry_q[head_q].wb_en;
  assign commit_rob_idx  = head_q;

  assign alloc_fire  = !rob_full && !flush;
  assign commit_fire = commit_valid && commit_ready && !flush;

  // Lane indices: valid lanes pack into consecutive entries from tail.
  always_comb begin
    logic [CNT_W-1:0] lane_off;
    lane_off     = '0;
    disp_rob_idx = '0;
    for (int unsigned i = 0; i < DISP_WIDTH; i++) begin
      lane_idx[i] = tail_q + IDX_W'(lane_off);
      disp_rob_idx[i*IDX_W +: IDX_W] = lane_idx[i];
      if (disp_valid[i]) begin
        lane_off = lane_off + CNT_W'(1);
      end
    end
    alloc_num = lane_off;
  end

  // Unpack per-port writeback indices.
  always_comb begin
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      wb_idx[p] = wb_rob_idx[p*IDX_W +: IDX_W];
    end
  end

  // Next-state: flush dominates; otherwise writeback, commit, then allocate.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      for (int unsigned e = 0; e < ROB_ENTRIES; e++) begin
        entry_d[e].valid = 1'b0;
        entry_d[e].done  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Completion only lands on entries already allocated before this edge.
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && entry_q[wb_idx[p]].valid) begin
          entry_d[wb_idx[p]].done = 1'b1;
        end
      end

      if (commit_fire) begin
        entry_d[head_q].valid = 1'b0;
        entry_d[head_q].done  = 1'b0;
        head_d                = head_q + IDX_W'(1);
      end

      // Allocation only targets free slots, so it never collides with head.
      if (alloc_fire) begin
        for (int unsigned i = 0; i < DISP_WIDTH; i++) begin
          if (disp_valid[i]) begin
            entry_d[lane_idx[i]].valid    = 1'b1;
            entry_d[lane_idx[i]].done     = 1'b0;
            entry_d[lane_idx[i]].dest_reg = disp_dest_reg[i*DEST_W +: DEST_W];
            entry_d[lane_idx[i]].wb_en    = disp_wb_en[i];
          end
        end
        tail_d = tail_q + IDX_W'(alloc_num);
      end

      count_d = count_q
              + (alloc_fire  ? alloc_num : CNT_W'(0))
              - (commit_fire ? CNT_W'(1) : CNT_W'(0));
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned e = 0; e < ROB_ENTRIES; e++) begin
        entry_q[e] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned e = 0; e < ROB_ENTRIES; e++) begin
        entry_q[e] <= entry_d[e];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
